// File: rtl/top_level_pkg.sv
// Shared constants, state encoding and decode helpers for the message encryptor.
package top_level_pkg;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned OUT_LEN   = 64;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LFSR_W    = 7;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned NUM_PTN   = 9;
  localparam int unsigned PTN_W     = 4;

  localparam int unsigned MSG_BASE  = 0;
  localparam int unsigned PRE_ADDR  = 61;
  localparam int unsigned PTN_ADDR  = 62;
  localparam int unsigned SEED_ADDR = 63;
  localparam int unsigned OUT_BASE  = 64;

  localparam int unsigned PRE_MIN   = 10;
  localparam int unsigned PRE_MAX   = 26;

  localparam logic [LFSR_W-1:0] TAP_TABLE [NUM_PTN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Selector 8 is the only value above 7 that maps to its own table entry.
  function automatic logic [PTN_W-1:0] ptn_decode(input logic [DATA_W-1:0] sel);
    if (sel == DATA_W'(8)) return PTN_W'(8);
    return {1'b0, sel[2:0]};
  endfunction

  function automatic logic [LFSR_W-1:0] tap_lookup(input logic [PTN_W-1:0] idx);
    if (idx < PTN_W'(NUM_PTN)) return TAP_TABLE[idx];
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] clamp_pre(input logic [DATA_W-1:0] raw);
    if (raw < DATA_W'(PRE_MIN)) return DATA_W'(PRE_MIN);
    if (raw > DATA_W'(PRE_MAX)) return DATA_W'(PRE_MAX);
    return raw;
  endfunction

  // An all-zero LFSR would lock up, so it is nudged to 1.
  function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] seed);
    if (seed == '0) return LFSR_W'(1);
    return seed;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: async reads, sync write, no reset so contents survive Reset.
module data_mem
  import top_level_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [LFSR_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_pre,
  output logic [DATA_W-1:0] o_ptn,
  output logic [LFSR_W-1:0] o_seed
);

  logic [DATA_W-1:0] Core [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) Core[i_waddr] <= i_wdata;
  end

  // Output bit 7 is always recomputed as parity, so message bit 7 is never needed.
  assign o_rdata = Core[i_raddr][LFSR_W-1:0];
  assign o_pre   = Core[PRE_ADDR];
  assign o_ptn   = Core[PTN_ADDR];
  assign o_seed  = Core[SEED_ADDR][LFSR_W-1:0];

endmodule

// File: rtl/top_level.sv
// Message encryptor: pads the message, XORs it with an LFSR stream, adds parity, writes results to DM.
module top_level
  import top_level_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  state_t              r_state, w_state_nxt;
  logic                r_ack, w_ack_nxt;
  logic [IDX_W-1:0]    r_i, w_i_nxt;
  logic [DATA_W-1:0]   r_pre, w_pre_nxt;
  logic [LFSR_W-1:0]   r_taps, w_taps_nxt;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;

  logic [DATA_W-1:0]   w_pre_raw;
  logic [DATA_W-1:0]   w_ptn_raw;
  logic [LFSR_W-1:0]   w_seed_raw;
  logic [LFSR_W-1:0]   w_msg;
  logic [ADDR_W-1:0]   w_pos;
  logic [ADDR_W-1:0]   w_raddr;
  logic [ADDR_W-1:0]   w_waddr;
  logic [LFSR_W-1:0]   w_pad;
  logic [LFSR_W-1:0]   w_x;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_fb;
  logic                w_we;

  data_mem DM (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_msg),
    .o_pre   (w_pre_raw),
    .o_ptn   (w_ptn_raw),
    .o_seed  (w_seed_raw)
  );

  // Byte datapath: the first pre positions are padding, the rest shift the message right.
  assign w_pos   = ADDR_W'(r_i);
  assign w_raddr = ADDR_W'(MSG_BASE) + w_pos - r_pre;
  assign w_waddr = ADDR_W'(OUT_BASE) + w_pos;
  assign w_pad   = (w_pos < r_pre) ? 7'h20 : w_msg;
  assign w_x     = w_pad ^ r_lfsr;
  assign w_wdata = {^w_x, w_x};
  assign w_fb    = ^(r_lfsr & r_taps);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_i     <= '0;
      r_pre   <= '0;
      r_taps  <= '0;
      r_lfsr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_i     <= w_i_nxt;
      r_pre   <= w_pre_nxt;
      r_taps  <= w_taps_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_i_nxt     = r_i;
    w_pre_nxt   = r_pre;
    w_taps_nxt  = r_taps;
    w_lfsr_nxt  = r_lfsr;
    w_we        = 1'b0;

    case (r_state)
      IDLE: begin
        w_ack_nxt = 1'b0;
        if (!Start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pre_nxt   = clamp_pre(w_pre_raw);
        w_taps_nxt  = tap_lookup(ptn_decode(w_ptn_raw));
        w_lfsr_nxt  = fix_seed(w_seed_raw);
        w_i_nxt     = '0;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_we       = 1'b1;
        w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_fb};
        w_i_nxt    = IDX_W'(r_i + IDX_W'(1));
        if (r_i == IDX_W'(OUT_LEN - 1)) begin
          w_state_nxt = DONE;
          w_ack_nxt   = 1'b1;
        end
      end
      DONE: begin
        if (Start) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  assign Ack = r_ack;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: preloads DM, runs encryptions, compares against an arithmetic model.
module tb_top_level;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int n_vec = 0;
  int n_err = 0;
  int mem_img [256];
  int tb_taps [9] = '{32'h60, 32'h48, 32'h78, 32'h72, 32'h6A, 32'h69, 32'h5C, 32'h7E, 32'h7B};
  int gold [64];

  top_level dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int v);
    mem_img[a] = v & 255;
    dut.DM.Core[a] = 8'(v);
  endtask

  task automatic setup(input int pre, input int ptn, input int seed, input bit rnd_msg);
    for (int k = 0; k < 61; k++) wr(k, rnd_msg ? int'($urandom_range(32, 126)) : 32);
    wr(61, pre);
    wr(62, ptn);
    wr(63, seed);
  endtask

  // Reference: clamp/decode/seed rules, then per-byte pad, XOR, parity and LFSR shift.
  function automatic void model();
    int pre, ptn, idx, taps, l, p, c;
    pre = mem_img[61];
    if (pre < 10) pre = 10;
    if (pre > 26) pre = 26;
    ptn = mem_img[62];
    idx = (ptn == 8) ? 8 : ptn % 8;
    taps = tb_taps[idx];
    l = mem_img[63] % 128;
    if (l == 0) l = 1;
    for (int i = 0; i < 64; i++) begin
      p = (i < pre) ? 32 : mem_img[i - pre];
      c = (p ^ l) % 128;
      gold[i] = c + 128 * ($countones(c) % 2);
      l = ((l * 2) % 128) + ($countones(l & taps) % 2);
    end
  endfunction

  task automatic run_and_check(input string tag, input bit raise_mid);
    int cnt;
    bit got;
    model();
    @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 200) begin
      @(posedge Clk); #1;
      cnt++;
      if (raise_mid && cnt == 30) Start = 1'b1;
      if (Ack === 1'b1) got = 1'b1;
    end
    chk({tag, "_latency"}, cnt, 66);
    if (!raise_mid) begin
      repeat (3) begin @(posedge Clk); #1; end
      chk({tag, "_ack_hold"}, int'(Ack), 1);
    end
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(dut.DM.Core[64 + i]), gold[i]);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "_ack_clear"}, int'(Ack), 0);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1;
    Start = 1'b1;
    for (int k = 0; k < 256; k++) wr(k, 0);
    for (int k = 0; k < 8; k++) wr(128 + k, 32'hA0 + k);
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ack", int'(Ack), 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("idle_ack", int'(Ack), 0);

    setup(10, 0, 1, 1'b0);
    run_and_check("basic", 1'b0);
    chk("basic_b64", int'(dut.DM.Core[64]), 32'h21);
    chk("basic_b65", int'(dut.DM.Core[65]), 32'h22);

    setup(10, 0, 3, 1'b0);
    run_and_check("seed3", 1'b0);
    chk("seed3_b64", int'(dut.DM.Core[64]), 32'hA3);

    setup(26, 0, int'($urandom_range(1, 127)), 1'b0);
    wr(0, 65); wr(1, 106); wr(2, 111); wr(3, 107);
    run_and_check("ajok", 1'b0);

    setup(int'($urandom_range(10, 26)), 8,     int'($urandom_range(1, 127)), 1'b1);
    run_and_check("ptn8", 1'b0);
    setup(int'($urandom_range(10, 26)), 'h0B,  int'($urandom_range(1, 127)), 1'b1);
    run_and_check("ptn0B", 1'b0);
    setup(int'($urandom_range(10, 26)), 'hF9,  int'($urandom_range(1, 127)), 1'b1);
    run_and_check("ptnF9", 1'b0);

    setup(3,  int'($urandom_range(0, 8)), int'($urandom_range(1, 127)), 1'b1);
    run_and_check("clamp_lo", 1'b0);
    setup(40, int'($urandom_range(0, 8)), int'($urandom_range(1, 127)), 1'b1);
    run_and_check("clamp_hi", 1'b0);
    setup(int'($urandom_range(10, 26)), int'($urandom_range(0, 8)), 0, 1'b1);
    run_and_check("seed0", 1'b0);

    for (int r = 0; r < 5; r++) begin
      setup(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'b1);
      run_and_check($sformatf("rnd%0d", r), r == 2);
    end

    // Reset while byte 20 is being produced.
    setup(int'($urandom_range(10, 26)), int'($urandom_range(0, 8)), int'($urandom_range(1, 127)), 1'b1);
    model();
    @(negedge Clk);
    Start = 1'b0;
    repeat (22) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk); #1;
    chk("midrun_reset_ack", int'(Ack), 0);
    chk("midrun_kept_b0", int'(dut.DM.Core[64]), gold[0]);
    @(negedge Clk);
    Reset = 1'b0;
    run_and_check("rerun", 1'b0);

    // Reset while holding DONE.
    setup(int'($urandom_range(10, 26)), int'($urandom_range(0, 8)), int'($urandom_range(1, 127)), 1'b1);
    @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    while (Ack !== 1'b1 && cnt < 200) begin @(posedge Clk); #1; cnt++; end
    chk("done_latency", cnt, 66);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("done_reset_ack", int'(Ack), 0);
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b1;
    @(posedge Clk); #1;
    chk("post_reset_idle", int'(Ack), 0);

    for (int k = 0; k < 8; k++)
      chk($sformatf("reserved%0d", 128 + k), int'(dut.DM.Core[128 + k]), 32'hA0 + k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Self-contained message encryptor that runs the program-1 encryption flow on its own data memory.
- The bench preloads the message and parameters into the memory, releases Start, and waits for Ack.
- The block builds a 64-byte space-padded message, XORs each byte with a 7-bit LFSR sequence, and writes the bit-6:0 parity into bit 7.
- Results land in memory bytes 64..127, read back hierarchically through instance DM, array Core.

Parameters:
- MEM_DEPTH, 256, data memory bytes (addresses 0..255).
- OUT_LEN, 64, number of encrypted output bytes.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  high holds the block idle; run begins while low after idle.
- Ack  output  1  high when the run is complete.

Behaviour:
- Memory map (DM.Core, 8-bit):
  - 0..60: message, pre-padded with 0x20.
  - 61: pre_length.
  - 62: pattern select.
  - 63: LFSR seed, bits 6:0 used.
  - 64..127: output.
  - 128..255: reserved; never written by the block.
- DM: asynchronous read, synchronous write, no reset; Core contents are never cleared by Reset.
- Reset: state IDLE, Ack=0, index i=0, all internal registers 0.
- FSM states and transitions:
  - IDLE: if Start=0, go to LOAD; otherwise stay.
  - LOAD (1 cycle): latch pre, taps and lfsr from DM[61..63]; i=0; go to RUN.
  - RUN (64 cycles, one byte per cycle): write DM[64+i]; advance lfsr and i; after i=63 go to DONE.
  - DONE: Ack=1; if Start=1, return to IDLE with Ack=0; otherwise hold.
- pre latch: clamp to 10..26 (value <10 becomes 10, >26 becomes 26).
- Pattern decode: idx = (DM[62]==8) ? 8 : DM[62][2:0].
- Tap table, idx 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- Seed: a seed of 0 is replaced by 0x01.
- Padded byte: p = (i < pre) ? 0x20 : DM[i-pre]. Source address is at most 53, so it never overlaps the output region.
- Output byte: c = p ^ {1'b0, lfsr}; c[7] = ^c[6:0]; DM[64+i] <= c.
- LFSR step (one per byte): lfsr <= {lfsr[5:0], ^(lfsr & taps)}.
- Latency: Ack rises 66 cycles after the first Clk edge with Start=0 in IDLE.
- Reset during LOAD/RUN/DONE: return to IDLE with Ack=0. Bytes already written stay in memory. A fresh run recomputes all 64 bytes.
- Start raised mid-run is ignored until DONE.

Decomposition:
- Package top_level_pkg holds:
  - Address constants: MSG_BASE=0, PRE_ADDR=61, PTN_ADDR=62, SEED_ADDR=63, OUT_BASE=64.
  - Clamp bounds 10 and 26.
  - The 9-entry tap table.
  - State enum {IDLE, LOAD, RUN, DONE}.
- One sub-module, data_mem, instantiated as DM with array Core[256].
- Datapath and FSM stay in top_level.

Test Plan:
- Reset; DM[0..60]=0x20, DM[61]=10, DM[62]=0, DM[63]=0x01; drop Start.
  - Required: DM[64]=0x21, DM[65]=0x22.
  - Required: Ack high 66 cycles later and held while Start=0.
- Seed 0x03, pt 0: DM[64]=0xA3 (parity bit set).
- Message "Ajok" at DM[0..3], pre=26.
  - Required: DM[64..89] are spaces XOR LFSR.
  - Required: DM[90] = 'A'^lfsr[26] with parity; full 64-byte golden-model match, score 64/64.
- Pattern decode, each with a golden-model compare:
  - DM[62]=8 uses taps 0x7B.
  - DM[62]=0x0B uses 0x72.
  - DM[62]=0xF9 uses 0x48.
- Clamp: DM[61]=3 behaves as 10; DM[61]=40 behaves as 26; DM[63]=0x00 behaves as seed 0x01.
- Reset asserted at RUN byte 20, then re-run.
  - Required: Ack=0 immediately; final output correct.
  - Required: DM[128..135] preloaded constants unchanged.
